// File: rtl/div_result_bcd.sv
// ============================================================================
// Module  : div_result_bcd
// Brief   : Signed quotient/remainder to sign + BCD digits via a shared
//           iterative double-dabble engine. Optional macro
//           DIV_BCD_ZERO_BLANK_EN blanks leading zero digits to 4'hF.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      quotient,
  input  logic [WIDTH-1:0]      remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  q_sign,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic                  r_sign,
  output logic [4*DIGITS-1:0]   r_bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_SHIFT = 1'b1;
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q_mag;
  logic [WIDTH-1:0] r_r_mag;
  logic [BW-1:0]    r_q_scr;
  logic [BW-1:0]    r_r_scr;
  logic             r_q_sign_int;
  logic             r_r_sign_int;
  logic             r_done;
  logic             r_q_sign;
  logic             r_r_sign;
  logic [BW-1:0]    r_q_bcd;
  logic [BW-1:0]    r_r_bcd;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_q_mag_in;
  logic [WIDTH-1:0] w_r_mag_in;
  logic [BW-1:0]    w_q_adj;
  logic [BW-1:0]    w_r_adj;
  logic [BW-1:0]    w_q_next;
  logic [BW-1:0]    w_r_next;

  // All nibbles are corrected from their pre-adjust values in parallel.
  function automatic logic [BW-1:0] f_add3(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    o = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) o[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return o;
  endfunction

`ifdef DIV_BCD_ZERO_BLANK_EN
  function automatic logic [BW-1:0] f_fmt(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    logic          lead;
    o    = s;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (s[4*i +: 4] == 4'd0)) o[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return o;
  endfunction
`else
  function automatic logic [BW-1:0] f_fmt(input logic [BW-1:0] s);
    return s;
  endfunction
`endif

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == C_LAST);
  assign w_q_mag_in = quotient[WIDTH-1]  ? (~quotient  + WIDTH'(1)) : quotient;
  assign w_r_mag_in = remainder[WIDTH-1] ? (~remainder + WIDTH'(1)) : remainder;
  assign w_q_adj    = f_add3(r_q_scr);
  assign w_r_adj    = f_add3(r_r_scr);
  assign w_q_next   = {w_q_adj[BW-2:0], r_q_mag[WIDTH-1]};
  assign w_r_next   = {w_r_adj[BW-2:0], r_r_mag[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_q_mag      <= '0;
      r_r_mag      <= '0;
      r_q_scr      <= '0;
      r_r_scr      <= '0;
      r_q_sign_int <= 1'b0;
      r_r_sign_int <= 1'b0;
      r_done       <= 1'b0;
      r_q_sign     <= 1'b0;
      r_r_sign     <= 1'b0;
      r_q_bcd      <= '0;
      r_r_bcd      <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_q_sign_int <= quotient[WIDTH-1];
        r_r_sign_int <= remainder[WIDTH-1];
        r_q_mag      <= w_q_mag_in;
        r_r_mag      <= w_r_mag_in;
        r_q_scr      <= '0;
        r_r_scr      <= '0;
        r_cnt        <= '0;
      end else if (r_state == S_SHIFT) begin
        r_q_scr <= w_q_next;
        r_r_scr <= w_r_next;
        r_q_mag <= {r_q_mag[WIDTH-2:0], 1'b0};
        r_r_mag <= {r_r_mag[WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_last) begin
        r_q_sign <= r_q_sign_int;
        r_r_sign <= r_r_sign_int;
        r_q_bcd  <= f_fmt(w_q_next);
        r_r_bcd  <= f_fmt(w_r_next);
      end
    end
  end

  assign done   = r_done;
  assign q_sign = r_q_sign;
  assign r_sign = r_r_sign;
  assign q_bcd  = r_q_bcd;
  assign r_bcd  = r_r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_div_result_bcd.sv
// ============================================================================
// Module  : tb_div_result_bcd
// Brief   : Self-checking bench for div_result_bcd: vector table, handshake
//           corner sequences and random operands against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  quotient = 8'h00;
  logic [7:0]  remainder = 8'h00;
  logic        busy;
  logic        done;
  logic        q_sign;
  logic [11:0] q_bcd;
  logic        r_sign;
  logic [11:0] r_bcd;

  int checks = 0;
  int errors = 0;

  div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done),
    .q_sign(q_sign), .q_bcd(q_bcd), .r_sign(r_sign), .r_bcd(r_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        qs;
    logic [11:0] qb;
    logic        rs;
    logic [11:0] rb;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [11:0] tb_blank(input logic [11:0] v);
    logic [11:0] o;
    o = v;
`ifdef DIV_BCD_ZERO_BLANK_EN
    if (v[11:8] == 4'd0) begin
      o[11:8] = 4'hF;
      if (v[7:4] == 4'd0) o[7:4] = 4'hF;
    end
`endif
    return o;
  endfunction

  // Decimal digits of the signed value's magnitude, straight from arithmetic.
  function automatic logic [11:0] model_bcd(input logic [7:0] v);
    int m;
    m = v[7] ? 256 - int'(v) : int'(v);
    return tb_blank({4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] q, input logic [7:0] r);
    @(negedge clk);
    quotient  = q;
    remainder = r;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic qs, input logic [11:0] qb,
                              input logic rs, input logic [11:0] rb);
    check({tag, ".q_sign"}, 32'(q_sign), 32'(qs));
    check({tag, ".q_bcd"},  32'(q_bcd),  32'(qb));
    check({tag, ".r_sign"}, 32'(r_sign), 32'(rs));
    check({tag, ".r_bcd"},  32'(r_bcd),  32'(rb));
  endtask

  initial begin
    int lat;
    int ndone;
    int cyc;
    int done_at;
    logic [11:0] seen_q;

    vecs[0] = '{8'h0C, 8'h03, 1'b0, 12'h012, 1'b0, 12'h003};
    vecs[1] = '{8'hF4, 8'hFD, 1'b1, 12'h012, 1'b1, 12'h003};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 12'h128, 1'b0, 12'h127};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 12'h000, 1'b0, 12'h000};
    vecs[4] = '{8'h69, 8'h07, 1'b0, 12'h105, 1'b0, 12'h007};
    vecs[5] = '{8'h81, 8'hFF, 1'b1, 12'h127, 1'b1, 12'h001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check_result("reset", 1'b0, 12'h000, 1'b0, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_start(vecs[i].q, vecs[i].r);
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'd1);
      wait_done(lat);
      check($sformatf("vec%0d.latency", i), 32'(lat), 32'd8);
      check_result($sformatf("vec%0d", i), vecs[i].qs, tb_blank(vecs[i].qb),
                   vecs[i].rs, tb_blank(vecs[i].rb));
      check($sformatf("vec%0d.busy_at_done", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.done_width", i), 32'(done), 32'd0);
      check_result($sformatf("vec%0d.hold", i), vecs[i].qs, tb_blank(vecs[i].qb),
                   vecs[i].rs, tb_blank(vecs[i].rb));
    end

    // start while busy is ignored
    do_start(8'h0C, 8'h03);
    cyc = 0;
    ndone = 0;
    done_at = -1;
    seen_q = 12'hxxx;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    quotient = 8'h63;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    while (cyc < 24) begin
      if (done) begin
        ndone++;
        if (done_at < 0) begin done_at = cyc; seen_q = q_bcd; end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_start.done_count", 32'(ndone), 32'd1);
    check("busy_start.latency", 32'(done_at), 32'd8);
    check("busy_start.q_bcd", 32'(seen_q), 32'(tb_blank(12'h012)));

    // start held in the done cycle is accepted
    do_start(8'h0C, 8'h03);
    wait_done(lat);
    check("back2back.first_latency", 32'(lat), 32'd8);
    quotient = 8'h05;
    remainder = 8'hFE;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("back2back.done_clear", 32'(done), 32'd0);
    check("back2back.busy", 32'(busy), 32'd1);
    check("back2back.q_hold", 32'(q_bcd), 32'(tb_blank(12'h012)));
    wait_done(lat);
    check("back2back.second_latency", 32'(lat), 32'd8);
    check_result("back2back", 1'b0, tb_blank(12'h005), 1'b1, tb_blank(12'h002));

    // Operands are sampled only at the accepting edge
    do_start(8'h0C, 8'h03);
    repeat (2) @(posedge clk);
    #1;
    quotient = 8'h63;
    remainder = 8'h50;
    wait_done(lat);
    check("input_change.latency", 32'(lat), 32'd6);
    check_result("input_change", 1'b0, tb_blank(12'h012), 1'b0, tb_blank(12'h003));

    // Asynchronous reset mid-conversion
    do_start(8'h0C, 8'h03);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check_result("midrst", 1'b0, 12'h000, 1'b0, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
    check("midrst.no_done", 32'(ndone), 32'd0);
    do_start(8'h05, 8'h00);
    wait_done(lat);
    check("midrst.fresh_latency", 32'(lat), 32'd8);
    check_result("midrst.fresh", 1'b0, tb_blank(12'h005), 1'b0, tb_blank(12'h000));

    // Random operands against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] rq;
      logic [7:0] rr;
      rq = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, 255));
      do_start(rq, rr);
      wait_done(lat);
      check($sformatf("rand%0d.latency", n), 32'(lat), 32'd8);
      check_result($sformatf("rand%0d(q=%h,r=%h)", n, rq, rr),
                   rq[7], model_bcd(rq), rr[7], model_bcd(rr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
